// File: rtl/inst_buffer_pkg.sv
// Shared pipeline types and default widths for the fetch-to-decode instruction buffer.
package inst_buffer_pkg;

  localparam int FETCH_WIDTH_DEF  = 4;
  localparam int DECODE_WIDTH_DEF = 2;
  localparam int DEPTH_DEF        = 16;

  typedef struct packed {
    logic       valid;
    logic [5:0] ecode;
    logic [8:0] sub_ecode;
  } excp_st;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] instr;
    excp_st      excp;
  } inst_buf_entry_st;

endpackage

// File: rtl/inst_buffer_lane_compactor.sv
// Prefix popcount of the fetch valid mask: per-lane write offset plus total lane count.
module lane_compactor #(
  parameter int FETCH_WIDTH = 4
) (
  input  logic [FETCH_WIDTH-1:0]                          valid,
  output logic [FETCH_WIDTH*$clog2(FETCH_WIDTH+1)-1:0]    offset,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]                total
);

  localparam int OW = $clog2(FETCH_WIDTH + 1);

  logic [OW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      offset[k*OW +: OW] = acc;
      acc = acc + OW'(valid[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between ICache output and decode; compacts fetch lanes in order.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int FETCH_WIDTH  = FETCH_WIDTH_DEF,
  parameter int DECODE_WIDTH = DECODE_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      a_rst_n,
  input  logic                      flush_i,
  input  logic [FETCH_WIDTH-1:0]    fetch_valid_i,
  output logic                      fetch_ready_o,
  input  logic [FETCH_WIDTH*32-1:0] fetch_vaddr_i,
  input  logic [FETCH_WIDTH*32-1:0] fetch_instr_i,
  input  logic                      fetch_excp_valid_i,
  input  logic [5:0]                fetch_excp_ecode_i,
  input  logic [8:0]                fetch_excp_sub_ecode_i,
  output logic [DECODE_WIDTH-1:0]   dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [DECODE_WIDTH*32-1:0] dec_vaddr_o,
  output logic [DECODE_WIDTH*32-1:0] dec_instr_o,
  output logic [DECODE_WIDTH-1:0]   dec_excp_valid_o,
  output logic [DECODE_WIDTH*6-1:0] dec_excp_ecode_o,
  output logic [DECODE_WIDTH*9-1:0] dec_excp_sub_ecode_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(FETCH_WIDTH + 1);

  // Handshake: a packet is taken only when fetch_ready_o is high at the edge; decode
  // takes every presented lane when dec_ready_i is high and lane 0 is valid.
  inst_buf_entry_st storage [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;

  logic [FETCH_WIDTH*OW-1:0] lane_off;
  logic [OW-1:0]             lane_total;
  logic [OW-1:0]             excp_lane;
  logic                      push, pop;
  logic [CW-1:0]             push_cnt, pop_cnt;
  inst_buf_entry_st          lane_entry [FETCH_WIDTH];
  inst_buf_entry_st          excp_entry;
  inst_buf_entry_st          rd_entry [DECODE_WIDTH];

  lane_compactor #(.FETCH_WIDTH(FETCH_WIDTH)) u_compactor (
    .valid  (fetch_valid_i),
    .offset (lane_off),
    .total  (lane_total)
  );

  always_comb begin
    excp_lane = '0;
    for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
      if (fetch_valid_i[k]) excp_lane = OW'(k);
    end
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lane_entry[k].vaddr = fetch_vaddr_i[k*32 +: 32];
      lane_entry[k].instr = fetch_instr_i[k*32 +: 32];
      lane_entry[k].excp  = '0;
    end
    excp_entry.vaddr          = fetch_vaddr_i[excp_lane*32 +: 32];
    excp_entry.instr          = fetch_instr_i[excp_lane*32 +: 32];
    excp_entry.excp.valid     = 1'b1;
    excp_entry.excp.ecode     = fetch_excp_ecode_i;
    excp_entry.excp.sub_ecode = fetch_excp_sub_ecode_i;
  end

  // Readiness looks only at the registered count so it never waits on a same-cycle pop.
  assign fetch_ready_o = (count <= CW'(DEPTH - FETCH_WIDTH));
  assign push          = (|fetch_valid_i) & fetch_ready_o & ~flush_i;
  assign push_cnt      = fetch_excp_valid_i ? CW'(1) : CW'(lane_total);
  assign pop           = dec_ready_i & dec_valid_o[0] & ~flush_i;
  assign pop_cnt       = (count >= CW'(DECODE_WIDTH)) ? CW'(DECODE_WIDTH) : count;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        if (fetch_excp_valid_i) begin
          storage[tail] <= excp_entry;
        end else begin
          for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (fetch_valid_i[k]) storage[tail + PW'(lane_off[k*OW +: OW])] <= lane_entry[k];
          end
        end
        tail <= tail + PW'(push_cnt);
      end
      if (pop) head <= head + PW'(pop_cnt);
      count <= count + (push ? push_cnt : '0) - (pop ? pop_cnt : '0);
    end
  end

  always_comb begin
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      rd_entry[j]    = storage[head + PW'(j)];
      dec_valid_o[j] = (CW'(j) < count);
      if (!dec_valid_o[j]) rd_entry[j] = '0;
      dec_vaddr_o[j*32 +: 32]        = rd_entry[j].vaddr;
      dec_instr_o[j*32 +: 32]        = rd_entry[j].instr;
      dec_excp_valid_o[j]            = rd_entry[j].excp.valid;
      dec_excp_ecode_o[j*6 +: 6]     = rd_entry[j].excp.ecode;
      dec_excp_sub_ecode_o[j*9 +: 9] = rd_entry[j].excp.sub_ecode;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: directed vector table, hand sequences and random traffic vs a queue model.
module tb_inst_buffer;

  localparam int FW    = 4;
  localparam int DW    = 2;
  localparam int DEPTH = 16;
  localparam logic [5:0] TLBR = 6'h3f;

  logic           clk;
  logic           a_rst_n;
  logic           flush_i;
  logic [FW-1:0]  fetch_valid_i;
  logic           fetch_ready_o;
  logic [FW*32-1:0] fetch_vaddr_i, fetch_instr_i;
  logic           fetch_excp_valid_i;
  logic [5:0]     fetch_excp_ecode_i;
  logic [8:0]     fetch_excp_sub_ecode_i;
  logic [DW-1:0]  dec_valid_o;
  logic           dec_ready_i;
  logic [DW*32-1:0] dec_vaddr_o, dec_instr_o;
  logic [DW-1:0]  dec_excp_valid_o;
  logic [DW*6-1:0] dec_excp_ecode_o;
  logic [DW*9-1:0] dec_excp_sub_ecode_o;

  inst_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_vaddr_i(fetch_vaddr_i), .fetch_instr_i(fetch_instr_i),
    .fetch_excp_valid_i(fetch_excp_valid_i), .fetch_excp_ecode_i(fetch_excp_ecode_i),
    .fetch_excp_sub_ecode_i(fetch_excp_sub_ecode_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_vaddr_o(dec_vaddr_o), .dec_instr_o(dec_instr_o),
    .dec_excp_valid_o(dec_excp_valid_o), .dec_excp_ecode_o(dec_excp_ecode_o),
    .dec_excp_sub_ecode_o(dec_excp_sub_ecode_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vaddr;
    logic [31:0] instr;
    logic        ev;
    logic [5:0]  ec;
    logic [8:0]  sc;
  } ent_t;

  typedef struct {
    logic [3:0] mask;
    logic       excp;
    logic       rdy;
    logic       fl;
    int         exp_cnt;
    logic       exp_rdy;
  } vec_t;

  ent_t        exp_q[$];
  vec_t        tbl[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    chk("fetch_ready", 64'(fetch_ready_o), 64'((DEPTH - sz) >= FW));
    chk("count", 64'(dut.count), 64'(sz));
    for (int j = 0; j < DW; j++) begin
      chk($sformatf("dec_valid[%0d]", j), 64'(dec_valid_o[j]), 64'(j < sz));
      if (j < sz) begin
        chk($sformatf("dec_vaddr[%0d]", j), 64'(dec_vaddr_o[j*32 +: 32]), 64'(exp_q[j].vaddr));
        chk($sformatf("dec_instr[%0d]", j), 64'(dec_instr_o[j*32 +: 32]), 64'(exp_q[j].instr));
        chk($sformatf("dec_excp_valid[%0d]", j), 64'(dec_excp_valid_o[j]), 64'(exp_q[j].ev));
        chk($sformatf("dec_ecode[%0d]", j), 64'(dec_excp_ecode_o[j*6 +: 6]), 64'(exp_q[j].ec));
        chk($sformatf("dec_sub_ecode[%0d]", j), 64'(dec_excp_sub_ecode_o[j*9 +: 9]), 64'(exp_q[j].sc));
      end
    end
  endtask

  // driver: apply one cycle of inputs, check current outputs, advance the model, cross the edge
  task automatic drive_cycle(input logic [3:0] mask, input logic excp, input logic [5:0] ec,
                             input logic [8:0] sc, input logic rdy, input logic fl);
    bit   can_push;
    int   had;
    int   first;
    ent_t e;
    fetch_valid_i          = mask;
    fetch_excp_valid_i     = excp;
    fetch_excp_ecode_i     = ec;
    fetch_excp_sub_ecode_i = sc;
    dec_ready_i            = rdy;
    flush_i                = fl;
    for (int k = 0; k < FW; k++) begin
      fetch_vaddr_i[k*32 +: 32] = pc_ctr + 32'(4 * k);
      fetch_instr_i[k*32 +: 32] = $urandom;
    end
    pc_ctr = pc_ctr + 32'd16;
    check_outputs();
    had      = exp_q.size();
    can_push = (DEPTH - had) >= FW;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rdy && had > 0) begin
        for (int n = 0; n < ((had < DW) ? had : DW); n++) void'(exp_q.pop_front());
      end
      if (mask != 4'b0 && can_push) begin
        if (excp) begin
          first = 0;
          while (!mask[first]) first++;
          e.vaddr = fetch_vaddr_i[first*32 +: 32];
          e.instr = fetch_instr_i[first*32 +: 32];
          e.ev = 1'b1; e.ec = ec; e.sc = sc;
          exp_q.push_back(e);
        end else begin
          for (int k = 0; k < FW; k++) begin
            if (mask[k]) begin
              e.vaddr = fetch_vaddr_i[k*32 +: 32];
              e.instr = fetch_instr_i[k*32 +: 32];
              e.ev = 1'b0; e.ec = '0; e.sc = '0;
              exp_q.push_back(e);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [3:0] mask, input logic excp, input logic rdy,
                         input logic fl, input int exp_cnt, input logic exp_rdy);
    vec_t v;
    v.mask = mask; v.excp = excp; v.rdy = rdy; v.fl = fl;
    v.exp_cnt = exp_cnt; v.exp_rdy = exp_rdy;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] wrap_base;
    a_rst_n = 1'b0;
    flush_i = 1'b0;
    fetch_valid_i = '0;
    fetch_vaddr_i = '0;
    fetch_instr_i = '0;
    fetch_excp_valid_i = 1'b0;
    fetch_excp_ecode_i = '0;
    fetch_excp_sub_ecode_i = '0;
    dec_ready_i = 1'b0;
    wrap_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(fetch_ready_o), 64'd1);
    chk("reset_valid", 64'(dec_valid_o), 64'd0);
    chk("reset_vaddr", 64'(dec_vaddr_o), 64'd0);
    chk("reset_instr", 64'(dec_instr_o), 64'd0);
    chk("reset_excp", 64'({dec_excp_valid_o, dec_excp_ecode_o, dec_excp_sub_ecode_o}), 64'd0);
    a_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // first packet streams out two lanes per cycle
    drive_cycle(4'b1111, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("first_lane0", 64'(dec_vaddr_o[31:0]), 64'h1c00_0000);
    chk("first_lane1", 64'(dec_vaddr_o[63:32]), 64'h1c00_0004);
    drive_cycle(4'b0000, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("second_lane0", 64'(dec_vaddr_o[31:0]), 64'h1c00_0008);
    chk("second_lane1", 64'(dec_vaddr_o[63:32]), 64'h1c00_000c);
    drive_cycle(4'b0000, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("drained_valid", 64'(dec_valid_o), 64'd0);

    // mask, fill, full-boundary, flush, exception and wrap vectors
    add_vec(4'b1100, 0, 0, 0, 2, 1);
    add_vec(4'b0000, 0, 1, 0, 0, 1);
    add_vec(4'b1111, 0, 0, 0, 4, 1);
    add_vec(4'b1111, 0, 0, 0, 8, 1);
    add_vec(4'b1111, 0, 0, 0, 12, 1);
    add_vec(4'b1111, 0, 0, 0, 16, 0);
    add_vec(4'b1111, 0, 0, 0, 16, 0);
    add_vec(4'b0000, 0, 1, 0, 14, 0);
    add_vec(4'b0001, 0, 0, 0, 14, 0);
    add_vec(4'b0000, 0, 0, 1, 0, 1);
    add_vec(4'b1111, 0, 0, 0, 4, 1);
    add_vec(4'b1111, 0, 0, 0, 8, 1);
    add_vec(4'b1111, 0, 0, 0, 12, 1);
    add_vec(4'b0001, 0, 0, 0, 13, 0);
    add_vec(4'b1111, 0, 1, 0, 11, 1);
    add_vec(4'b0000, 0, 0, 1, 0, 1);
    add_vec(4'b1111, 0, 0, 0, 4, 1);
    add_vec(4'b0011, 0, 0, 0, 6, 1);
    add_vec(4'b1111, 0, 1, 1, 0, 1);
    add_vec(4'b1111, 1, 0, 0, 1, 1);
    add_vec(4'b0000, 0, 1, 0, 0, 1);
    add_vec(4'b0000, 0, 0, 1, 0, 1);
    add_vec(4'b1111, 0, 0, 0, 4, 1);
    add_vec(4'b1111, 0, 0, 0, 8, 1);
    add_vec(4'b1111, 0, 0, 0, 12, 1);
    add_vec(4'b0011, 0, 0, 0, 14, 0);
    for (int i = 0; i < 7; i++) add_vec(4'b0000, 0, 1, 0, 12 - 2 * i, 1);
    add_vec(4'b1111, 0, 0, 0, 4, 1);
    add_vec(4'b0000, 0, 1, 0, 2, 1);
    add_vec(4'b0000, 0, 1, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 33) wrap_base = pc_ctr;
      drive_cycle(tbl[i].mask, tbl[i].excp, TLBR, 9'h0, tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl%0d_count", i), 64'(dut.count), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_ready", i), 64'(fetch_ready_o), 64'(tbl[i].exp_rdy));
      if (i == 19) begin
        chk("excp_lane0_valid", 64'(dec_excp_valid_o[0]), 64'd1);
        chk("excp_lane0_ecode", 64'(dec_excp_ecode_o[5:0]), 64'(TLBR));
      end
      if (i == 33) begin
        chk("wrap_slot14", 64'(dut.storage[14].vaddr), 64'(wrap_base));
        chk("wrap_slot0", 64'(dut.storage[0].vaddr), 64'(wrap_base + 32'd8));
        chk("wrap_slot1", 64'(dut.storage[1].vaddr), 64'(wrap_base + 32'd12));
      end
    end

    // random traffic: first half leans toward filling, second half toward draining
    for (int c = 0; c < 600; c++) begin
      drive_cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                  6'($urandom_range(0, 63)), 9'($urandom_range(0, 511)),
                  (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 59) == 0));
    end

    // asynchronous reset mid-operation
    drive_cycle(4'b1111, 1'b0, '0, '0, 1'b0, 1'b0);
    drive_cycle(4'b1111, 1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(dut.count), 64'd0);
    chk("async_rst_ready", 64'(fetch_ready_o), 64'd1);
    chk("async_rst_valid", 64'(dec_valid_o), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    drive_cycle(4'b0101, 1'b0, '0, '0, 1'b0, 1'b0);
    drive_cycle(4'b0000, 1'b0, '0, '0, 1'b1, 1'b0);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
